pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage LC3b pipeline. Drives the load enables
//  of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and the bubble/flush controls for those registers.

---
 rtl/pipeline_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage LC3b pipeline: split I/D miss tracking,
// load-use bubbles, taken-branch flushes and saturating stall/bubble counters.
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    input  logic [2:0]       ex_dest,
    input  logic             ex_is_load,
    input  logic             br_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             wb_bubble,
    output logic             flush,
    output logic             imem_mask,
    output logic             dmem_mask,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] luse_bubbles
);

    typedef enum logic [1:0] {RUN, WAIT_BOTH, WAIT_I, WAIT_D} state_e;

    state_e           state_q, state_d, fsm_nxt, run_nxt;
    logic             imem_mask_q, imem_mask_d;
    logic             dmem_mask_q, dmem_mask_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] luse_cnt_q, luse_cnt_d;
    logic             imiss, dmiss, stall, luse;

    assign imem_mask    = imem_mask_q;
    assign dmem_mask    = dmem_mask_q;
    assign stall_cycles = stall_cnt_q;
    assign luse_bubbles = luse_cnt_q;

    // Miss tracking, hazard detection, enables and counter updates.
    always_comb begin
        imiss = imem_read & ~imem_mask_q & ~imem_resp;
        dmiss = dmem_req & ~dmem_mask_q & ~dmem_resp;
        luse  = ex_is_load & ((id_use_sr1 & (id_sr1 == ex_dest)) |
                              (id_use_sr2 & (id_sr2 == ex_dest)));

        if (imiss && dmiss)  run_nxt = WAIT_BOTH;
        else if (imiss)      run_nxt = WAIT_I;
        else if (dmiss)      run_nxt = WAIT_D;
        else                 run_nxt = RUN;

        fsm_nxt     = state_q;
        imem_mask_d = imem_mask_q;
        dmem_mask_d = dmem_mask_q;
        case (state_q)
            RUN:       fsm_nxt = run_nxt;
            WAIT_BOTH: begin
                if (imem_resp && dmem_resp) begin
                    fsm_nxt = RUN;
                end else if (imem_resp) begin
                    fsm_nxt     = WAIT_D;
                    imem_mask_d = 1'b1;
                end else if (dmem_resp) begin
                    fsm_nxt     = WAIT_I;
                    dmem_mask_d = 1'b1;
                end
            end
            // A completing side may coincide with a fresh miss on the other side.
            WAIT_I:    if (imem_resp) fsm_nxt = run_nxt;
            WAIT_D:    if (dmem_resp) fsm_nxt = run_nxt;
            default:   fsm_nxt = RUN;
        endcase
        if (fsm_nxt == RUN) begin
            imem_mask_d = 1'b0;
            dmem_mask_d = 1'b0;
        end

        stall        = (fsm_nxt != RUN);
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        wb_bubble    = 1'b0;
        flush        = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        luse_cnt_d   = luse_cnt_q;
        state_d      = fsm_nxt;

        if (!reset_n) begin
            state_d     = RUN;
            imem_mask_d = 1'b0;
            dmem_mask_d = 1'b0;
            stall_cnt_d = '0;
            luse_cnt_d  = '0;
        end else if (stall) begin
            // Keep WB moving so the retiring instruction commits exactly once.
            load_mem_wb = 1'b1;
            wb_bubble   = 1'b1;
            if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (br_taken) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush       = 1'b1;
        end else if (luse) begin
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            bubble_id_ex = 1'b1;
            if (luse_cnt_q != {CNT_W{1'b1}}) luse_cnt_d = luse_cnt_q + CNT_W'(1);
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        imem_mask_q <= imem_mask_d;
        dmem_mask_q <= dmem_mask_d;
        stall_cnt_q <= stall_cnt_d;
        luse_cnt_q  <= luse_cnt_d;
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (16-bit and 4-bit counter instances).
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic reset_n, imem_read, imem_resp, dmem_req, dmem_resp;
    logic [2:0] id_sr1, id_sr2, ex_dest;
    logic id_use_sr1, id_use_sr2, ex_is_load, br_taken;

    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic bubble_id_ex, wb_bubble, flush, imem_mask, dmem_mask;
    logic [15:0] stall_cycles, luse_bubbles;

    logic s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
    logic s_bubble_id_ex, s_wb_bubble, s_flush, s_imem_mask, s_dmem_mask;
    logic [3:0] s_stall_cycles, s_luse_bubbles;

    int total = 0;
    int bad = 0;

    logic [4:0] loads;
    logic [2:0] ctl;
    assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    assign ctl   = {bubble_id_ex, wb_bubble, flush};

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2), .ex_dest(ex_dest),
        .ex_is_load(ex_is_load), .br_taken(br_taken), .load_pc(load_pc),
        .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
        .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex), .wb_bubble(wb_bubble),
        .flush(flush), .imem_mask(imem_mask), .dmem_mask(dmem_mask),
        .stall_cycles(stall_cycles), .luse_bubbles(luse_bubbles)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2), .ex_dest(ex_dest),
        .ex_is_load(ex_is_load), .br_taken(br_taken), .load_pc(s_load_pc),
        .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex), .load_ex_mem(s_load_ex_mem),
        .load_mem_wb(s_load_mem_wb), .bubble_id_ex(s_bubble_id_ex), .wb_bubble(s_wb_bubble),
        .flush(s_flush), .imem_mask(s_imem_mask), .dmem_mask(s_dmem_mask),
        .stall_cycles(s_stall_cycles), .luse_bubbles(s_luse_bubbles)
    );

    task automatic idle();
        imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_use_sr1 = 0; id_use_sr2 = 0;
        ex_dest = 3'd7; ex_is_load = 0; br_taken = 0;
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(); reset_n = 0; idle();
        cyc(); cyc(); reset_n = 1;
    endtask

    task automatic test_reset();
        cyc(); reset_n = 0; idle(); br_taken = 1; imem_read = 1; #1;
        total++; if (loads !== 5'b00000 || flush !== 1'b0) begin
            bad++; $display("FAIL reset_outputs loads=%b flush=%b exp loads=00000 flush=0", loads, flush);
        end
        cyc(); idle(); #1;
        cyc(); reset_n = 1; #1;
        total++; if (stall_cycles !== 16'd0 || luse_bubbles !== 16'd0 || imem_mask !== 1'b0 || dmem_mask !== 1'b0) begin
            bad++; $display("FAIL reset_state stall=%0d luse=%0d im=%b dm=%b exp 0 0 0 0",
                            stall_cycles, luse_bubbles, imem_mask, dmem_mask);
        end
        total++; if (loads !== 5'b11111 || ctl !== 3'b000) begin
            bad++; $display("FAIL reset_run loads=%b ctl=%b exp 11111 000", loads, ctl);
        end
    endtask

    task automatic test_imiss();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(); imem_read = 1; imem_resp = 0; #1;
            total++; if (loads !== 5'b00001 || ctl !== 3'b010) begin
                bad++; $display("FAIL imiss_stall c=%0d loads=%b ctl=%b exp 00001 010", c, loads, ctl);
            end
        end
        cyc(); imem_resp = 1; #1;
        total++; if (loads !== 5'b11111 || ctl !== 3'b000) begin
            bad++; $display("FAIL imiss_release loads=%b ctl=%b exp 11111 000", loads, ctl);
        end
        cyc(); idle(); #1;
        total++; if (stall_cycles !== 16'd3) begin
            bad++; $display("FAIL imiss_count got=%0d exp=3", stall_cycles);
        end
    endtask

    task automatic test_split();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc(); imem_read = 1; dmem_req = 1;
            dmem_resp = (c == 2); imem_resp = (c == 5); #1;
            if (c < 5) begin
                total++; if (loads !== 5'b00001 || wb_bubble !== 1'b1) begin
                    bad++; $display("FAIL split_stall c=%0d loads=%b wbb=%b exp 00001 1", c, loads, wb_bubble);
                end
            end else begin
                total++; if (loads !== 5'b11111 || wb_bubble !== 1'b0) begin
                    bad++; $display("FAIL split_release loads=%b wbb=%b exp 11111 0", loads, wb_bubble);
                end
            end
            total++; if (dmem_mask !== (c >= 3) || imem_mask !== 1'b0) begin
                bad++; $display("FAIL split_mask c=%0d dm=%b im=%b exp dm=%b im=0", c, dmem_mask, imem_mask, c >= 3);
            end
        end
        cyc(); idle(); #1;
        total++; if (stall_cycles !== 16'd5 || dmem_mask !== 1'b0) begin
            bad++; $display("FAIL split_end stall=%0d dm=%b exp 5 0", stall_cycles, dmem_mask);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(); ex_is_load = 1; ex_dest = 3'd3; id_sr1 = 3'd3; id_use_sr1 = 1; #1;
        total++; if (loads !== 5'b00111 || ctl !== 3'b100) begin
            bad++; $display("FAIL luse_sr1 loads=%b ctl=%b exp 00111 100", loads, ctl);
        end
        cyc(); ex_is_load = 0; #1;
        total++; if (loads !== 5'b11111 || ctl !== 3'b000 || luse_bubbles !== 16'd1) begin
            bad++; $display("FAIL luse_after loads=%b ctl=%b luse=%0d exp 11111 000 1", loads, ctl, luse_bubbles);
        end
        cyc(); ex_is_load = 1; id_use_sr1 = 0; #1;
        total++; if (loads !== 5'b11111 || bubble_id_ex !== 1'b0) begin
            bad++; $display("FAIL luse_unused loads=%b bub=%b exp 11111 0", loads, bubble_id_ex);
        end
        cyc(); id_sr1 = 3'd5; id_use_sr1 = 1; id_sr2 = 3'd3; id_use_sr2 = 1; #1;
        total++; if (loads !== 5'b00111 || bubble_id_ex !== 1'b1) begin
            bad++; $display("FAIL luse_sr2 loads=%b bub=%b exp 00111 1", loads, bubble_id_ex);
        end
        cyc(); idle(); #1;
        total++; if (luse_bubbles !== 16'd2 || stall_cycles !== 16'd0) begin
            bad++; $display("FAIL luse_count luse=%0d stall=%0d exp 2 0", luse_bubbles, stall_cycles);
        end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(); br_taken = 1; ex_is_load = 1; ex_dest = 3'd3; id_sr1 = 3'd3; id_use_sr1 = 1; #1;
        total++; if (loads !== 5'b11111 || ctl !== 3'b001) begin
            bad++; $display("FAIL br_vs_luse loads=%b ctl=%b exp 11111 001", loads, ctl);
        end
        cyc(); idle(); #1;
        total++; if (flush !== 1'b0 || luse_bubbles !== 16'd0) begin
            bad++; $display("FAIL br_after flush=%b luse=%0d exp 0 0", flush, luse_bubbles);
        end
        cyc(); br_taken = 1; imem_read = 1; #1;
        total++; if (loads !== 5'b00001 || ctl !== 3'b010) begin
            bad++; $display("FAIL br_in_stall loads=%b ctl=%b exp 00001 010", loads, ctl);
        end
        cyc(); imem_resp = 1; #1;
        total++; if (loads !== 5'b11111 || ctl !== 3'b001) begin
            bad++; $display("FAIL br_release loads=%b ctl=%b exp 11111 001", loads, ctl);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(); imem_read = 1; dmem_req = 1; #1;
        cyc(); imem_resp = 1; #1;
        cyc(); imem_resp = 0; #1;
        total++; if (imem_mask !== 1'b1 || loads !== 5'b00001) begin
            bad++; $display("FAIL rmid_waitd im=%b loads=%b exp 1 00001", imem_mask, loads);
        end
        cyc(); reset_n = 0; #1;
        total++; if (loads !== 5'b00000 || flush !== 1'b0) begin
            bad++; $display("FAIL rmid_in_reset loads=%b flush=%b exp 00000 0", loads, flush);
        end
        cyc(); reset_n = 1; idle(); #1;
        total++; if (loads !== 5'b11111 || imem_mask !== 1'b0 || dmem_mask !== 1'b0 || stall_cycles !== 16'd0) begin
            bad++; $display("FAIL rmid_after loads=%b im=%b dm=%b stall=%0d exp 11111 0 0 0",
                            loads, imem_mask, dmem_mask, stall_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc(); imem_read = 1; #1;
        end
        cyc(); imem_resp = 1; #1;
        cyc(); idle(); #1;
        total++; if (s_stall_cycles !== 4'd15 || stall_cycles !== 16'd20) begin
            bad++; $display("FAIL sat_stall got4=%0d got16=%0d exp 15 20", s_stall_cycles, stall_cycles);
        end
        for (int c = 0; c < 20; c++) begin
            cyc(); ex_is_load = 1; ex_dest = 3'd2; id_sr2 = 3'd2; id_use_sr2 = 1; #1;
        end
        cyc(); idle(); #1;
        total++; if (s_luse_bubbles !== 4'd15 || luse_bubbles !== 16'd20) begin
            bad++; $display("FAIL sat_luse got4=%0d got16=%0d exp 15 20", s_luse_bubbles, luse_bubbles);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; idle();
        test_reset();
        test_imiss();
        test_split();
        test_load_use();
        test_branch();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
